// File: rtl/upower_mc_datapath.sv
// upower_mc_datapath: multi-cycle uPOWER integer datapath with req/ack memory port and 32-entry register file
module upower_mc_datapath #(
    parameter int XLEN     = 64,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic [4:0]        dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);
    localparam int AL = $clog2(XLEN / 8);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    state_t            state, nxt;
    logic [31:0]       ir;
    logic [XLEN-1:0]   rf [32];
    logic [XLEN-1:0]   res, alu, rs_v, ra_v, rb_v, ra0, exts_d, zext_d;
    logic [ADDR_W-1:0] ea;
    logic [4:0]        wr_idx, wr_sel;
    logic [1:0]        code;
    logic [CW-1:0]     cnt;
    logic              wr_en, st_r, legal, mem_op, st, wr, misal, last;
    logic [5:0]        op;
    logic [4:0]        rt, ra, rb;
    logic [9:0]        xo;

    assign op     = ir[31:26];
    assign rt     = ir[25:21];
    assign ra     = ir[20:16];
    assign rb     = ir[15:11];
    assign xo     = ir[10:1];
    assign rs_v   = rf[rt];
    assign ra_v   = rf[ra];
    assign rb_v   = rf[rb];
    assign ra0    = (ra == 5'd0) ? '0 : ra_v;
    assign exts_d = XLEN'($signed(ir[15:0]));
    assign zext_d = XLEN'(ir[15:0]);
    assign ea     = ra0[ADDR_W-1:0] + ADDR_W'($signed({ir[15:2], 2'b00}));
    assign misal  = |ea[AL-1:0];
    assign last   = cnt == CW'(MAX_WAIT - 1);

    assign instr_ready = state == IDLE;
    assign busy        = state != IDLE;
    assign mem_req     = state == MEM;
    assign mem_we      = mem_req & st_r;
    assign done        = state == WB;
    assign err         = done & (|code);
    assign err_code    = done ? code : 2'd0;
    assign dbg_data    = rf[dbg_addr];

    // decode the latched instruction and compute the ALU result / write target
    always_comb begin
        legal  = 1'b0;
        mem_op = 1'b0;
        st     = 1'b0;
        wr     = 1'b0;
        wr_sel = rt;
        alu    = '0;
        case (op)
            6'd14: begin legal = 1'b1; wr = 1'b1; alu = ra0 + exts_d; end
            6'd24: begin legal = 1'b1; wr = 1'b1; wr_sel = ra; alu = rs_v | zext_d; end
            6'd28: begin legal = 1'b1; wr = 1'b1; wr_sel = ra; alu = rs_v & zext_d; end
            6'd58: begin legal = ir[1:0] == 2'b00; mem_op = 1'b1; wr = 1'b1; end
            6'd62: begin legal = ir[1:0] == 2'b00; mem_op = 1'b1; st = 1'b1; end
            6'd31: begin
                case (xo)
                    10'd266: begin legal = 1'b1; wr = 1'b1; alu = ra_v + rb_v; end
                    10'd40:  begin legal = 1'b1; wr = 1'b1; alu = rb_v - ra_v; end
                    10'd28:  begin legal = 1'b1; wr = 1'b1; wr_sel = ra; alu = rs_v & rb_v; end
                    10'd444: begin legal = 1'b1; wr = 1'b1; wr_sel = ra; alu = rs_v | rb_v; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= nxt;

    // next-state logic: only aligned legal ld/std visit MEM
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = instr_valid ? EXEC : IDLE;
            EXEC:    nxt = (legal && mem_op && !misal) ? MEM : WB;
            MEM:     nxt = (mem_ack || last) ? WB : MEM;
            default: nxt = IDLE;
        endcase
    end

    // instruction latch, execute results, memory port registers and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir        <= '0;
            res       <= '0;
            code      <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            st_r      <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (instr_valid) ir <= instr;
                EXEC: begin
                    code      <= !legal ? 2'd1 : (mem_op && misal) ? 2'd2 : 2'd0;
                    res       <= alu;
                    wr_en     <= wr;
                    wr_idx    <= wr_sel;
                    st_r      <= st;
                    mem_addr  <= ea;
                    mem_wdata <= rs_v;
                    cnt       <= '0;
                end
                MEM: begin
                    if (mem_ack)   res  <= mem_rdata;
                    else if (last) code <= 2'd3;
                    else           cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // register file write at the closing edge of a fault-free WB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (state == WB && wr_en && code == 2'd0) begin
            rf[wr_idx] <= res;
        end
    end
endmodule

// File: tb/tb_upower_mc_datapath.sv
// tb_upower_mc_datapath: table-driven check of ALU, load/store, faults, timeout and reset
module tb_upower_mc_datapath;
    logic        clk = 0, rst = 0, instr_valid = 0, mem_ack = 0;
    logic [31:0] instr = 0;
    logic [63:0] mem_rdata = 0;
    logic [4:0]  dbg_addr = 0;
    logic        instr_ready, mem_req, mem_we, busy, done, err;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata, dbg_data;
    logic [1:0]  err_code;

    upower_mc_datapath #(.XLEN(64), .ADDR_W(16), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          ack;
        logic [63:0] rdata;
        logic [1:0]  code;
        int          lat;
        int          req;
        bit          cm;
        logic        we;
        logic [15:0] addr;
        logic [63:0] wd;
        bit          cw;
        logic [4:0]  idx;
        logic [63:0] val;
    } vec_t;

    vec_t        v [16];
    int          n_vec = 0, n_bad = 0;
    int          r_lat, r_req;
    logic [1:0]  r_code;
    logic        r_err, r_we;
    logic [15:0] r_addr;
    logic [63:0] r_wd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] in, input int ack_cyc, input logic [63:0] rd);
        int m;
        bit got;
        @(negedge clk);
        instr = in;
        instr_valid = 1;
        @(posedge clk);
        #1 instr_valid = 0;
        r_lat = 1; r_req = 0; m = 0; got = 0;
        r_we = 0; r_addr = 0; r_wd = 0; r_code = 0; r_err = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (done) begin
                got = 1;
                r_code = err_code;
                r_err = err;
            end else begin
                if (mem_req) begin
                    m++;
                    r_req++;
                    r_we = mem_we;
                    r_addr = mem_addr;
                    r_wd = mem_wdata;
                end
                mem_ack = mem_req && (m == ack_cyc);
                mem_rdata = rd;
                @(posedge clk);
                #1 r_lat++;
            end
        end
        mem_ack = 0;
        chk("done_seen", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{32'h3A200014, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd17, 64'd20};
        v[1]  = '{32'h3A91FFFF, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd20, 64'd19};
        v[2]  = '{32'h7CB1A214, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd5,  64'd39};
        v[3]  = '{32'h7CD1A050, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd6,  64'hFFFF_FFFF_FFFF_FFFF};
        v[4]  = '{32'hFA200008, 3, 64'h0,    2'd0, 5,  3, 1, 1, 16'd8,  64'd20, 1, 5'd17, 64'd20};
        v[5]  = '{32'hE8600008, 1, 64'hDEAD, 2'd0, 3,  1, 1, 0, 16'd8,  64'd0,  0, 5'd3,  64'hDEAD};
        v[6]  = '{32'hE8600004, 1, 64'hBEEF, 2'd2, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd3,  64'hDEAD};
        v[7]  = '{32'h00000000, 0, 64'h0,    2'd1, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd0,  64'd0};
        v[8]  = '{32'hFA200010, 0, 64'h0,    2'd3, 10, 8, 1, 1, 16'd16, 64'd20, 1, 5'd17, 64'd20};
        v[9]  = '{32'h60A78000, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd7,  64'h8027};
        v[10] = '{32'h70C8F0F0, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd8,  64'hF0F0};
        v[11] = '{32'h7CE91B78, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd9,  64'hDEAF};
        v[12] = '{32'h7D2A4038, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd10, 64'hD0A0};
        v[13] = '{32'h7C000000, 0, 64'h0,    2'd1, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd0,  64'd0};
        v[14] = '{32'hE8600009, 1, 64'h1234, 2'd1, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd3,  64'hDEAD};
        v[15] = '{32'h7D863214, 0, 64'h0,    2'd0, 2,  0, 0, 0, 16'd0,  64'd0,  0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(instr_ready), 64'd1);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1 chk("rst_rf", dbg_data, 64'd0);
        end
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < 16; i++) begin
            run(v[i].instr, v[i].ack, v[i].rdata);
            chk("err_code", 64'(r_code), 64'(v[i].code));
            chk("err", 64'(r_err), 64'(v[i].code != 2'd0));
            chk("latency", 64'(r_lat), 64'(v[i].lat));
            chk("req_cycles", 64'(r_req), 64'(v[i].req));
            if (v[i].cm) begin
                chk("mem_we", 64'(r_we), 64'(v[i].we));
                chk("mem_addr", 64'(r_addr), 64'(v[i].addr));
            end
            if (v[i].cw) chk("mem_wdata", r_wd, v[i].wd);
            dbg_addr = v[i].idx;
            #1 chk("reg", dbg_data, v[i].val);
            chk("idle_ready", 64'(instr_ready), 64'd1);
            chk("idle_err_code", 64'(err_code), 64'd0);
        end

        @(negedge clk);
        mem_ack = 1;
        instr = 32'hFA200010;
        instr_valid = 1;
        @(posedge clk);
        #1 instr_valid = 0;
        chk("exec_busy", 64'(busy), 64'd1);
        chk("exec_ready", 64'(instr_ready), 64'd0);
        chk("exec_no_req", 64'(mem_req), 64'd0);
        mem_ack = 0;
        @(posedge clk);
        #1;
        chk("mid_mem_req", 64'(mem_req), 64'd1);
        chk("mid_mem_we", 64'(mem_we), 64'd1);
        chk("mid_mem_addr", 64'(mem_addr), 64'd16);
        chk("mid_mem_wdata", mem_wdata, 64'd20);
        @(posedge clk);
        dbg_addr = 5'd17;
        #2 rst = 0;
        #1;
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        chk("arst_mem_we", 64'(mem_we), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(instr_ready), 64'd1);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_wdata", mem_wdata, 64'd0);
        chk("arst_rf", dbg_data, 64'd0);
        @(negedge clk);
        rst = 1;
        run(32'h3A200014, 0, 64'h0);
        chk("recover_lat", 64'(r_lat), 64'd2);
        dbg_addr = 5'd17;
        #1 chk("recover_reg", dbg_data, 64'd20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
